// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               FSM state encoding, requester port id, default depth.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_DEPTH_DEFAULT = 1024;
  localparam int DATA_W             = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  // The port that is not p; used to hand the round-robin pointer over.
  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : MEM_DEPTH x 64-bit storage, synchronous write, combinational
//               read on a single shared index. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Write port: one word per clock when enabled; no reset on the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter in front of a single-ported data memory.
//               Port 0 = pipeline memory stage, port 1 = loader/debug.
//               IDLE -> ACCESS -> RESP, one access in flight, fixed latency.
//               Signed word addresses are bounds-checked; out-of-range
//               accesses raise err, never write and return zero data.
//               Build option: define DMEM_ARB_RR_EN for round-robin on ties;
//               otherwise port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              busy
);

  localparam int                IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic              grant_valid;
  port_id_t          grant_port;

  // Payload captured at grant; the requester may change its inputs afterwards.
  port_id_t          port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Response captured at the edge leaving ACCESS, presented during RESP.
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ARB_RR_EN
  port_id_t          rr_ptr;
`endif

  // Signed range check: a set sign bit means negative, so only the upper
  // bound needs comparing once the sign bit is known clear.
  assign in_range = ~addr_q[ADDR_W-1] && (addr_q <= MAX_ADDR);
  assign mem_we   = (state == ACCESS) && we_q && in_range;

  dmem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Winner selection among the live requests.
  always_comb begin
    grant_valid = p0_req | p1_req;
    grant_port  = PORT0;
`ifdef DMEM_ARB_RR_EN
    if (p0_req && p1_req) begin
      grant_port = rr_ptr;
    end else if (p1_req) begin
      grant_port = PORT1;
    end
`else
    if (!p0_req && p1_req) begin
      grant_port = PORT1;
    end
`endif
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer hands priority to the other port after every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= PORT0;
    end else if (state == IDLE && grant_valid) begin
      rr_ptr <= other_port(grant_port);
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic: fixed three-step walk once a request is granted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner's payload and port id at grant time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q  <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && grant_valid) begin
      port_q  <= grant_port;
      we_q    <= (grant_port == PORT1) ? p1_we    : p0_we;
      addr_q  <= (grant_port == PORT1) ? p1_addr  : p0_addr;
      wdata_q <= (grant_port == PORT1) ? p1_wdata : p0_wdata;
    end
  end

  // Capture the access result; writes and out-of-range accesses return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      err_q   <= ~in_range;
      rdata_q <= (!we_q && in_range) ? mem_rdata : '0;
    end
  end

  assign busy     = (state != IDLE);
  assign p0_done  = (state == RESP) && (port_q == PORT0);
  assign p1_done  = (state == RESP) && (port_q == PORT1);
  assign p0_rdata = p0_done ? rdata_q : '0;
  assign p1_rdata = p1_done ? rdata_q : '0;
  assign p0_err   = p0_done & err_q;
  assign p1_err   = p1_done & err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_done, p0_err, p1_done, p1_err, busy;
  logic [63:0] p0_rdata, p1_rdata;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  dmem_arbiter #(
    .MEM_DEPTH (1024),
    .ADDR_W    (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_done  (p0_done),
    .p0_rdata (p0_rdata),
    .p0_err   (p0_err),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_done  (p1_done),
    .p1_rdata (p1_rdata),
    .p1_err   (p1_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic access(input string tag, input int port, input logic we,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err);
    drive(port, 1'b1, we, addr, wdata);
    @(negedge clk);
    check({tag, "_acc_busy"}, 64'(busy), 64'd1);
    check({tag, "_acc_done"}, {62'd0, p0_done, p1_done}, 64'd0);
    @(negedge clk);
    check({tag, "_done"}, {62'd0, p0_done, p1_done}, (port == 0) ? 64'd2 : 64'd1);
    check({tag, "_rdata"}, (port == 0) ? p0_rdata : p1_rdata, exp_rdata);
    check({tag, "_err"}, 64'((port == 0) ? p0_err : p1_err), 64'(exp_err));
    drive(port, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] exp_win;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", {62'd0, p0_done, p1_done}, 64'd0);
    check("rst_rdata", p0_rdata | p1_rdata, 64'd0);
    check("rst_err", {62'd0, p0_err, p1_err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write/read round trip on port 0.
    access("p0_wr5", 0, 1'b1, 64'd5, 64'hDEAD, 64'd0, 1'b0);
    access("p0_rd5", 0, 1'b0, 64'd5, 64'd0, 64'hDEAD, 1'b0);

    // Seed known contents through port 1.
    access("p1_wr0", 1, 1'b1, 64'd0, 64'h1234, 64'd0, 1'b0);
    access("p1_wr9", 1, 1'b1, 64'd9, 64'h99, 64'd0, 1'b0);
    access("p0_wr3", 0, 1'b1, 64'd3, 64'h333, 64'd0, 1'b0);
    access("p0_wr4", 0, 1'b1, 64'd4, 64'h444, 64'd0, 1'b0);
    access("p1_rd1023", 1, 1'b0, 64'd1023, 64'd0, 64'hX, 1'b0 === 1'b1);

    // Out-of-range accesses: error, zero data, no aliasing write.
    access("p1_rd1024", 1, 1'b0, 64'd1024, 64'd0, 64'd0, 1'b1);
    access("p1_rdneg", 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1);
    access("p1_wr1024", 1, 1'b1, 64'd1024, 64'd7, 64'd0, 1'b1);
    access("p1_rd0", 1, 1'b0, 64'd0, 64'd0, 64'h1234, 1'b0);

    // Payload change during ACCESS must not affect the latched address.
    drive(0, 1'b1, 1'b0, 64'd3, 64'd0);
    @(negedge clk);
    check("chg_busy_n1", 64'(busy), 64'd1);
    p0_addr = 64'd4;
    @(negedge clk);
    check("chg_busy_n2", 64'(busy), 64'd1);
    check("chg_rdata", p0_rdata, 64'h333);
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("chg_busy_n3", 64'(busy), 64'd0);

    // Reset during ACCESS aborts the write and suppresses done.
    drive(0, 1'b1, 1'b1, 64'd9, 64'h55);
    @(negedge clk);
    check("abort_acc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", {62'd0, p0_done, p1_done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    access("abort_rd9", 0, 1'b0, 64'd9, 64'd0, 64'h99, 1'b0);

    // Ties: both held for 4 rounds, starting from a freshly reset pointer.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 64'd5, 64'd0);
    drive(1, 1'b1, 1'b0, 64'd0, 64'd0);
    for (int r = 0; r < 4; r++) begin
`ifdef DMEM_ARB_RR_EN
      exp_win = (r % 2 == 0) ? 64'd2 : 64'd1;
`else
      exp_win = 64'd2;
`endif
      @(negedge clk);
      @(negedge clk);
      check($sformatf("tie_r%0d_done", r), {62'd0, p0_done, p1_done}, exp_win);
      check($sformatf("tie_r%0d_rdata", r), p0_rdata | p1_rdata,
            (exp_win == 64'd2) ? 64'hDEAD : 64'h1234);
      @(negedge clk);
    end
    // Release port 0; port 1 is still pending and must be served next.
    drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("tie_tail_done", {62'd0, p0_done, p1_done}, 64'd1);
    check("tie_tail_rdata", p1_rdata, 64'h1234);
    drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("tie_tail_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, number of 64-bit data-memory words.
REQ-002 SHALL have parameter ADDR_W, default 64, width of requester addresses (signed).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports p0_req/p1_req  input  1  access request; port 0 = pipeline memory stage, port 1 = loader/debug.
REQ-006 SHALL have ports p0_we/p1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports p0_addr/p1_addr  input  ADDR_W  signed word address.
REQ-008 SHALL have ports p0_wdata/p1_wdata  input  64  write data.
REQ-009 SHALL have ports p0_done/p1_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports p0_rdata/p1_rdata  output  64  read data, valid while done=1.
REQ-011 SHALL have ports p0_err/p1_err  output  1  out-of-range address flag, valid while done=1.
REQ-012 SHALL have port busy  output  1  1 whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one access in flight at a time.
REQ-014 IDLE: if any req=1, SHALL select a winner, latch its we/addr/wdata and port id, and go to ACCESS on the next edge; otherwise stay in IDLE.
REQ-015 ACCESS: SHALL perform the memory read or write at the edge leaving ACCESS, using latched values only.
REQ-016 RESP: SHALL assert the winner's done for exactly one cycle with rdata/err; loser's done stays 0.
REQ-017 Latency SHALL be fixed: req sampled at edge N -> done high in cycle N+2 -> IDLE at N+3.
REQ-018 Address is in range iff 0 <= addr <= MEM_DEPTH-1 (signed compare); otherwise err=1, no write occurs, rdata=0.
REQ-019 A write SHALL return rdata=0; a read SHALL return mem[addr].
REQ-020 Requesters SHALL hold req and payload stable until their done; the block SHALL ignore payload changes after latching.
REQ-021 A req still high in the cycle after done SHALL be treated as a new request.
REQ-022 With both req=1 in IDLE, the winner SHALL follow REQ-026; the loser stays pending and is served next with no lost request.
REQ-023 Outputs done/err SHALL be 0 and rdata SHALL be 0 in all states except RESP.

Reset
REQ-024 rst=1 SHALL force IDLE, busy=0, all done/err=0, rdata=0, clear latched payload and round-robin pointer (pointer = port 0).
REQ-025 Reset during ACCESS SHALL abort: no memory write occurs, no done pulse; memory array contents are NOT reset.

Configuration
REQ-026 Macro DMEM_ARB_RR_EN: defined -> round-robin, pointer toggles to the other port after each grant; undefined -> fixed priority, port 0 always wins ties.

Structure
REQ-027 Shared package dmem_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP), port-id type and MEM_DEPTH default constant.
REQ-028 Storage SHALL be a sub-module dmem_array (synchronous write, combinational read, MEM_DEPTH x 64, no reset).
REQ-029 Arbitration, bounds check and FSM SHALL live in dmem_arbiter.

Verification
REQ-030 p0 write addr=5 data=0xDEAD, then p0 read addr=5 -> p0_done at N+2 each time, p0_rdata=0xDEAD, p0_err=0.
REQ-031 p1 read addr=1024 and addr=-1 -> p1_err=1, p1_rdata=0; p1 write addr=1024 data=7 followed by read addr=0 -> no wrap/alias, mem[0] unchanged.
REQ-032 p0 and p1 req together, held, 4 rounds -> with DMEM_ARB_RR_EN grants alternate 0,1,0,1; without, p0 wins every tie while held.
REQ-033 rst pulse during ACCESS of p0 write addr=9 data=0x55 -> no done, busy=0 next cycle, later read of addr=9 returns its pre-reset value.
REQ-034 p0 changes addr from 3 to 4 while in ACCESS -> access uses addr=3; busy=1 from N+1 through N+2, 0 at N+3.
